// File: rtl/regfile_read_arbiter.sv
// Arbitrates the shared register-file read mux between the rs/rt operand fetchers and a
// debug register-dump sequencer; register 0 reads bypass the port and return zero.
module regfile_read_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic              rs_ready,
    output logic              rs_rvalid,
    output logic [DATA_W-1:0] rs_rdata,
    input  logic              rt_valid,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rt_ready,
    output logic              rt_rvalid,
    output logic [DATA_W-1:0] rt_rdata,
    output logic [ADDR_W-1:0] mux_sel,
    input  logic [DATA_W-1:0] mux_data,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    typedef enum logic {StIdle, StDump} state_t;

    localparam logic LastRs = 1'b0;
    localparam logic LastRt = 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
    logic              last_q, last_d;

    logic rs_nz, rt_nz, rs_zero, rt_zero;
    logic rs_grant, rt_grant, dump_grant, dump_last;

    always_comb begin
        rs_nz   = rs_valid && (rs_addr != '0);
        rt_nz   = rt_valid && (rt_addr != '0);
        rs_zero = rs_valid && (rs_addr == '0);
        rt_zero = rt_valid && (rt_addr == '0);

        // Grants are forced low during reset so every output reads zero while rst is high.
        rs_grant   = !rst && rs_nz && (!rt_nz || last_q == LastRt);
        rt_grant   = !rst && rt_nz && !rs_grant;
        dump_grant = !rst && (state_q == StDump) && !rs_nz && !rt_nz;
        dump_last  = (dump_idx_q == '1);

        rs_ready = rs_grant || (!rst && rs_zero);
        rt_ready = rt_grant || (!rst && rt_zero);

        mux_sel = '0;
        if (rs_grant) begin
            mux_sel = rs_addr;
        end else if (rt_grant) begin
            mux_sel = rt_addr;
        end else if (dump_grant) begin
            mux_sel = dump_idx_q;
        end

        last_d = last_q;
        if (rs_grant) begin
            last_d = LastRs;
        end else if (rt_grant) begin
            last_d = LastRt;
        end

        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d    = StDump;
                    dump_idx_d = '0;
                end
            end
            StDump: begin
                if (dump_grant) begin
                    // Index wraps naturally to zero on the final register.
                    dump_idx_d = dump_idx_q + 1'b1;
                    if (dump_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        dump_busy = (state_q == StDump);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            dump_idx_q <= '0;
            last_q     <= LastRt;
        end else begin
            state_q    <= state_d;
            dump_idx_q <= dump_idx_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_rvalid  <= 1'b0;
            rs_rdata   <= '0;
            rt_rvalid  <= 1'b0;
            rt_rdata   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            rs_rvalid  <= rs_ready;
            rt_rvalid  <= rt_ready;
            dump_valid <= dump_grant;
            dump_done  <= dump_grant && dump_last;
            if (rs_ready) begin
                rs_rdata <= rs_zero ? '0 : mux_data;
            end
            if (rt_ready) begin
                rt_rdata <= rt_zero ? '0 : mux_data;
            end
            if (dump_grant) begin
                dump_addr <= dump_idx_q;
                dump_data <= mux_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter: operand reads, zero bypass,
// round-robin contention, full and interrupted register dumps, and reset mid-dump.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rs_valid = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic        rs_ready, rs_rvalid;
    logic [31:0] rs_rdata;
    logic        rt_valid = 1'b0;
    logic [4:0]  rt_addr = '0;
    logic        rt_ready, rt_rvalid;
    logic [31:0] rt_rdata;
    logic [4:0]  mux_sel;
    logic [31:0] mux_data;
    logic        dump_start = 1'b0;
    logic        dump_busy, dump_valid, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    // Register-file mux model: either a fixed word or 0x100 + selected index.
    logic        mux_mode = 1'b0;
    logic [31:0] mux_const = '0;
    always_comb mux_data = mux_mode ? (32'h100 + 32'(mux_sel)) : mux_const;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_read_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_valid   (rs_valid),
        .rs_addr    (rs_addr),
        .rs_ready   (rs_ready),
        .rs_rvalid  (rs_rvalid),
        .rs_rdata   (rs_rdata),
        .rt_valid   (rt_valid),
        .rt_addr    (rt_addr),
        .rt_ready   (rt_ready),
        .rt_rvalid  (rt_rvalid),
        .rt_rdata   (rt_rdata),
        .mux_sel    (mux_sel),
        .mux_data   (mux_data),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rs_ready"}, 32'(rs_ready), 0);
        check({tag, "_rt_ready"}, 32'(rt_ready), 0);
        check({tag, "_rs_rvalid"}, 32'(rs_rvalid), 0);
        check({tag, "_rt_rvalid"}, 32'(rt_rvalid), 0);
        check({tag, "_rs_rdata"}, rs_rdata, 0);
        check({tag, "_rt_rdata"}, rt_rdata, 0);
        check({tag, "_mux_sel"}, 32'(mux_sel), 0);
        check({tag, "_dump_busy"}, 32'(dump_busy), 0);
        check({tag, "_dump_valid"}, 32'(dump_valid), 0);
        check({tag, "_dump_addr"}, 32'(dump_addr), 0);
        check({tag, "_dump_data"}, dump_data, 0);
        check({tag, "_dump_done"}, 32'(dump_done), 0);
    endtask

    initial begin
        int cnt;
        int extra;
        logic [4:0] exp_sel [4];
        exp_sel[0] = 5'd3;
        exp_sel[1] = 5'd7;
        exp_sel[2] = 5'd3;
        exp_sel[3] = 5'd7;

        // Reset state
        #2;
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // Single rs read
        rs_valid  = 1'b1;
        rs_addr   = 5'd5;
        mux_const = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_rs_ready", 32'(rs_ready), 1);
        check("t1_mux_sel", 32'(mux_sel), 5);
        tick();
        rs_valid = 1'b0;
        check("t1_rs_rvalid", 32'(rs_rvalid), 1);
        check("t1_rs_rdata", rs_rdata, 32'hDEADBEEF);
        mux_const = 32'h0;
        tick();
        check("t1_rvalid_pulse", 32'(rs_rvalid), 0);
        check("t1_rdata_hold", rs_rdata, 32'hDEADBEEF);

        // Round-robin contention after reset: rs first
        do_reset();
        mux_mode = 1'b1;
        rs_valid = 1'b1;
        rs_addr  = 5'd3;
        rt_valid = 1'b1;
        rt_addr  = 5'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_mux_sel", 32'(mux_sel), 32'(exp_sel[i]));
            check("t2_rs_ready", 32'(rs_ready), 32'(i % 2 == 0));
            check("t2_rt_ready", 32'(rt_ready), 32'(i % 2 == 1));
            tick();
            if (i % 2 == 0) check("t2_rs_rdata", rs_rdata, 32'h103);
            else            check("t2_rt_rdata", rt_rdata, 32'h107);
        end

        // Zero bypass alongside a port read
        rs_addr = 5'd0;
        rt_addr = 5'd9;
        @(negedge clk);
        check("t3_rs_ready", 32'(rs_ready), 1);
        check("t3_rt_ready", 32'(rt_ready), 1);
        check("t3_mux_sel", 32'(mux_sel), 9);
        tick();
        rs_valid = 1'b0;
        rt_valid = 1'b0;
        check("t3_rs_rvalid", 32'(rs_rvalid), 1);
        check("t3_rs_rdata", rs_rdata, 0);
        check("t3_rt_rvalid", 32'(rt_rvalid), 1);
        check("t3_rt_rdata", rt_rdata, 32'h109);

        // Full uninterrupted dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("t4_busy", 32'(dump_busy), 1);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 32; c++) begin
            tick();
            if (dump_valid) begin
                check("t4_addr", 32'(dump_addr), 32'(cnt));
                check("t4_data", dump_data, 32'h100 + 32'(cnt));
                check("t4_done", 32'(dump_done), 32'(cnt == 31));
                cnt++;
            end
        end
        check("t4_count", 32'(cnt), 32);
        check("t4_busy_end", 32'(dump_busy), 0);
        tick();
        check("t4_valid_pulse", 32'(dump_valid), 0);
        check("t4_addr_hold", 32'(dump_addr), 31);

        // Dump frozen by rs traffic; second dump_start ignored
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        rs_addr = 5'd4;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 32; c++) begin
            rs_valid   = (c >= 8 && c < 18);
            dump_start = (c == 10);
            tick();
            if (c >= 8 && c < 18) begin
                check("t5_frozen", 32'(dump_valid), 0);
                check("t5_rs_rdata", rs_rdata, 32'h104);
            end
            if (dump_valid) begin
                check("t5_addr", 32'(dump_addr), 32'(cnt));
                cnt++;
            end
        end
        rs_valid   = 1'b0;
        dump_start = 1'b0;
        check("t5_count", 32'(cnt), 32);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dump_valid) extra++;
        end
        check("t5_no_restart", 32'(extra), 0);

        // Reset mid-dump at index 12
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 12; c++) begin
            tick();
            if (dump_valid) cnt++;
        end
        check("t6_reached", 32'(dump_addr), 11);
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        tick();
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dump_valid || dump_busy) extra++;
        end
        check("t6_quiet", 32'(extra), 0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        check("t6_restart_valid", 32'(dump_valid), 1);
        check("t6_restart_addr", 32'(dump_addr), 0);
        check("t6_restart_data", dump_data, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
